// File: rtl/trace_line_arbiter_pkg.sv
// Shared types and constants for the trace line arbiter: FSM states,
// line delimiter characters and the round-robin pointer helper.
package trace_line_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LINE      = 3'd1,
        ST_RESULT    = 3'd2,
        ST_ABORT     = 3'd3,
        ST_ABORT_RES = 3'd4
    } arb_state_e;

    localparam logic [7:0] CHAR_START       = 8'h5E; // '^'
    localparam logic [7:0] CHAR_END         = 8'h23; // '#'
    localparam logic [7:0] DEF_IDLE_CHAR    = 8'h00;
    localparam logic [7:0] DEF_ABORT_CHAR   = 8'h0A;

    // Pointer position just after the given source, wrapping at n.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1) % n;
    endfunction

endpackage

// File: rtl/trace_line_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from ptr_i, wrapping modulo N.
module trace_line_arbiter_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] winner_o,
    output logic         found_o
);

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && req_i[(int'(ptr_i) + k) % N]) begin
                found_o  = 1'b1;
                winner_o = W'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/trace_line_arbiter.sv
// Shares one cpu_checker among N_SRC trace sources, one whole '^'..'#' line
// at a time, and returns the checker verdict tagged with the source id.
module trace_line_arbiter
    import trace_line_arbiter_pkg::*;
#(
    parameter int         N_SRC      = 4,
    parameter int         SRC_W      = 2,
    parameter int         MAX_LEN    = 64,
    parameter logic [7:0] IDLE_CHAR  = DEF_IDLE_CHAR,
    parameter logic [7:0] ABORT_CHAR = DEF_ABORT_CHAR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      src_valid,
    input  logic [8*N_SRC-1:0]    src_char,
    input  logic [16*N_SRC-1:0]   src_freq,
    output logic [N_SRC-1:0]      src_ready,
    output logic [7:0]            chk_char,
    output logic [15:0]           chk_freq,
    input  logic [1:0]            chk_format_type,
    input  logic [3:0]            chk_error_code,
    output logic                  res_valid,
    output logic [SRC_W-1:0]      res_src,
    output logic [1:0]            res_format,
    output logic [3:0]            res_error,
    output logic                  res_abort
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] owner_q, owner_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      freq_q, freq_d;

    logic             res_valid_q, res_valid_d;
    logic [SRC_W-1:0] res_src_q, res_src_d;
    logic [1:0]       res_format_q, res_format_d;
    logic [3:0]       res_error_q, res_error_d;
    logic             res_abort_q, res_abort_d;

    logic [N_SRC-1:0] req;
    logic [SRC_W-1:0] pick_winner;
    logic             pick_found;
    logic [7:0]       own_char;
    logic [15:0]      win_freq;
    logic [LEN_W-1:0] len_inc;

    always_comb begin
        req = '0;
        for (int i = 0; i < N_SRC; i++) begin
            req[i] = src_valid[i] && (src_char[8*i +: 8] == CHAR_START);
        end
    end

    trace_line_arbiter_rr_pick #(
        .N (N_SRC),
        .W (SRC_W)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_winner),
        .found_o  (pick_found)
    );

    assign own_char = src_char[8*int'(owner_q) +: 8];
    assign win_freq = src_freq[16*int'(pick_winner) +: 16];
    assign len_inc  = (len_q == LEN_W'(MAX_LEN)) ? len_q : len_q + 1'b1;

    // The checker eats a character every cycle, so every state names chk_char
    // explicitly; a missing owner character is turned into ABORT_CHAR.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        len_d        = len_q;
        freq_d       = freq_q;
        res_valid_d  = 1'b0;
        res_src_d    = res_src_q;
        res_format_d = res_format_q;
        res_error_d  = res_error_q;
        res_abort_d  = res_abort_q;
        src_ready    = '0;
        chk_char     = IDLE_CHAR;
        chk_freq     = freq_q;

        unique case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (src_valid[i] && (src_char[8*i +: 8] != CHAR_START)) begin
                        src_ready[i] = 1'b1;
                    end
                end
                if (pick_found) begin
                    src_ready[pick_winner] = 1'b1;
                    chk_char = CHAR_START;
                    chk_freq = win_freq;
                    owner_d  = pick_winner;
                    freq_d   = win_freq;
                    rr_ptr_d = SRC_W'(rr_next(int'(pick_winner), N_SRC));
                    len_d    = LEN_W'(1);
                    state_d  = ST_LINE;
                end
            end

            ST_LINE: begin
                if (src_valid[owner_q]) begin
                    src_ready[owner_q] = 1'b1;
                    chk_char = own_char;
                    len_d    = len_inc;
                    if (own_char == CHAR_END) begin
                        state_d = ST_RESULT;
                    end else if (len_inc >= LEN_W'(MAX_LEN)) begin
                        state_d = ST_ABORT;
                    end
                end else begin
                    chk_char = ABORT_CHAR;
                    state_d  = ST_ABORT_RES;
                end
            end

            ST_RESULT: begin
                res_valid_d  = 1'b1;
                res_src_d    = owner_q;
                res_format_d = chk_format_type;
                res_error_d  = chk_error_code;
                res_abort_d  = 1'b0;
                state_d      = ST_IDLE;
            end

            ST_ABORT: begin
                chk_char = ABORT_CHAR;
                state_d  = ST_ABORT_RES;
            end

            ST_ABORT_RES: begin
                // Drain the rest of the broken line, including its '#'.
                if (src_valid[owner_q]) begin
                    src_ready[owner_q] = 1'b1;
                end
                if (!src_valid[owner_q] || (own_char == CHAR_END)) begin
                    res_valid_d  = 1'b1;
                    res_src_d    = owner_q;
                    res_format_d = 2'b00;
                    res_error_d  = 4'b0000;
                    res_abort_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            len_q        <= '0;
            freq_q       <= '0;
            res_valid_q  <= 1'b0;
            res_src_q    <= '0;
            res_format_q <= '0;
            res_error_q  <= '0;
            res_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            len_q        <= len_d;
            freq_q       <= freq_d;
            res_valid_q  <= res_valid_d;
            res_src_q    <= res_src_d;
            res_format_q <= res_format_d;
            res_error_q  <= res_error_d;
            res_abort_q  <= res_abort_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_src    = res_src_q;
    assign res_format = res_format_q;
    assign res_error  = res_error_q;
    assign res_abort  = res_abort_q;

endmodule

// File: tb/tb_trace_line_arbiter.sv
// Directed bench for trace_line_arbiter: line forwarding, round-robin grant,
// bubble and over-length aborts, IDLE drain and asynchronous reset.
module tb_trace_line_arbiter;
    import trace_line_arbiter_pkg::*;

    logic         clk;
    logic         reset;
    logic [3:0]   src_valid;
    logic [31:0]  src_char;
    logic [63:0]  src_freq;
    logic [3:0]   src_ready;
    logic [7:0]   chk_char;
    logic [15:0]  chk_freq;
    logic [1:0]   chk_format_type;
    logic [3:0]   chk_error_code;
    logic         res_valid;
    logic [1:0]   res_src;
    logic [1:0]   res_format;
    logic [3:0]   res_error;
    logic         res_abort;

    int n_checks = 0;
    int n_errors = 0;
    string long_s;

    trace_line_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .src_valid       (src_valid),
        .src_char        (src_char),
        .src_freq        (src_freq),
        .src_ready       (src_ready),
        .chk_char        (chk_char),
        .chk_freq        (chk_freq),
        .chk_format_type (chk_format_type),
        .chk_error_code  (chk_error_code),
        .res_valid       (res_valid),
        .res_src         (res_src),
        .res_format      (res_format),
        .res_error       (res_error),
        .res_abort       (res_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int src, input logic v, input logic [7:0] ch);
        src_valid[src]      = v;
        src_char[8*src +: 8] = ch;
    endtask

    // Feeds every character of s from one source, one per cycle, expecting
    // it forwarded to the checker with only that source consuming.
    task automatic send_line(input int src, input string s, input logic [15:0] fq);
        for (int k = 0; k < s.len(); k++) begin
            set_src(src, 1'b1, s[k]);
            #1;
            check("line_char", 32'(chk_char), 32'(s[k]));
            check("line_ready", 32'(src_ready), 32'(1 << src));
            check("line_freq", 32'(chk_freq), 32'(fq));
            step();
        end
        src_valid[src] = 1'b0;
    endtask

    // Called in the RESULT cycle: presents the verdict, then checks the pulse.
    task automatic finish_result(input logic [1:0] fmt, input logic [3:0] err, input int src);
        chk_format_type = fmt;
        chk_error_code  = err;
        #1;
        check("rslt_chk_char", 32'(chk_char), 32'h00);
        check("rslt_ready", 32'(src_ready), 32'h0);
        check("rslt_pending", 32'(res_valid), 32'h0);
        step();
        chk_format_type = 2'b00;
        chk_error_code  = 4'b0000;
        #1;
        check("res_valid", 32'(res_valid), 32'h1);
        check("res_src", 32'(res_src), 32'(src));
        check("res_format", 32'(res_format), 32'(fmt));
        check("res_error", 32'(res_error), 32'(err));
        check("res_abort", 32'(res_abort), 32'h0);
        check("rslt_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        reset           = 1'b0;
        src_valid       = '0;
        src_char        = '0;
        src_freq        = '0;
        chk_format_type = '0;
        chk_error_code  = '0;
        #2;
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_src", 32'(res_src), 32'h0);
        check("rst_chk_freq", 32'(chk_freq), 32'h0);
        check("rst_chk_char", 32'(chk_char), 32'h00);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        step();
        step();
        reset = 1'b1;

        // Single source line, checker accepts with format 01.
        src_freq[15:0] = 16'd4;
        send_line(0, "^10@00003000: $1 <= 0000000a#", 16'd4);
        finish_result(2'b01, 4'b0000, 0);
        step();
        check("pulse_one_cycle", 32'(res_valid), 32'h0);

        // Source 3 with freq 8, checker flags error bit 1.
        src_freq[63:48] = 16'd8;
        send_line(3, "^10@00002ffc: $1 <= 0000000a#", 16'd8);
        finish_result(2'b01, 4'b0010, 3);
        check("rr_ptr_wrap", 32'(dut.rr_ptr_q), 32'h0);

        // Sources 1 and 2 request together; 1 wins, 2 waits for the next IDLE.
        src_freq[31:16] = 16'd3;
        src_freq[47:32] = 16'd6;
        set_src(2, 1'b1, 8'h5E);
        send_line(1, "^a#", 16'd3);
        finish_result(2'b01, 4'b0000, 1);
        send_line(2, "^bb#", 16'd6);
        finish_result(2'b01, 4'b0001, 2);
        check("rr_ptr_after_two", 32'(dut.rr_ptr_q), 32'h3);

        // Owner bubble after 5 characters.
        src_freq[15:0] = 16'd5;
        send_line(0, "^1234", 16'd5);
        #1;
        check("bubble_abort_char", 32'(chk_char), 32'h0A);
        check("bubble_ready", 32'(src_ready), 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] tail;
            tail = "567#";
            set_src(0, 1'b1, tail[31-8*k -: 8]);
            #1;
            check("drain_ready", 32'(src_ready), 32'h1);
            check("drain_chk_char", 32'(chk_char), 32'h00);
            step();
        end
        src_valid[0] = 1'b0;
        #1;
        check("bubble_res_valid", 32'(res_valid), 32'h1);
        check("bubble_res_abort", 32'(res_abort), 32'h1);
        check("bubble_res_src", 32'(res_src), 32'h0);
        check("bubble_res_format", 32'(res_format), 32'h0);
        check("bubble_res_error", 32'(res_error), 32'h0);
        check("bubble_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Over-length line from source 1; source 2 waits behind it.
        long_s = "^";
        for (int i = 0; i < 63; i++) long_s = {long_s, "a"};
        src_freq[31:16] = 16'd7;
        src_freq[47:32] = 16'd9;
        send_line(1, long_s, 16'd7);
        set_src(1, 1'b1, 8'h62);
        set_src(2, 1'b1, 8'h5E);
        #1;
        check("long_abort_char", 32'(chk_char), 32'h0A);
        check("long_abort_ready", 32'(src_ready), 32'h0);
        step();
        #1;
        check("long_drain_b", 32'(src_ready), 32'h2);
        check("long_drain_char", 32'(chk_char), 32'h00);
        step();
        set_src(1, 1'b1, 8'h23);
        #1;
        check("long_drain_end", 32'(src_ready), 32'h2);
        step();
        src_valid[1] = 1'b0;
        #1;
        check("long_res_valid", 32'(res_valid), 32'h1);
        check("long_res_abort", 32'(res_abort), 32'h1);
        check("long_res_src", 32'(res_src), 32'h1);
        check("long_next_grant", 32'(src_ready), 32'h4);
        check("long_next_freq", 32'(chk_freq), 32'd9);
        send_line(2, "^ok#", 16'd9);
        finish_result(2'b10, 4'h3, 2);

        // IDLE drain of non-'^' heads, then reset in the middle of a line.
        src_freq[15:0] = 16'd11;
        set_src(0, 1'b1, 8'h78);
        #1;
        check("drain_x_ready", 32'(src_ready), 32'h1);
        check("drain_x_char", 32'(chk_char), 32'h00);
        step();
        set_src(0, 1'b1, 8'h79);
        #1;
        check("drain_y_ready", 32'(src_ready), 32'h1);
        step();
        send_line(0, "^ab", 16'd11);
        set_src(0, 1'b1, 8'h63);
        #1;
        check("midline_state", 32'(dut.state_q), 32'(ST_LINE));
        reset = 1'b0;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'h0);
        check("arst_res_src", 32'(res_src), 32'h0);
        check("arst_res_format", 32'(res_format), 32'h0);
        check("arst_res_error", 32'(res_error), 32'h0);
        check("arst_res_abort", 32'(res_abort), 32'h0);
        check("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("arst_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);
        check("arst_chk_freq", 32'(chk_freq), 32'h0);
        check("arst_chk_char", 32'(chk_char), 32'h00);
        src_valid = '0;
        step();
        step();
        reset = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trace_line_arbiter.md
Name: trace_line_arbiter

Overview:
- Shares one cpu_checker instance among N trace sources.
- Grants the checker's character input to one source for a whole trace line, from '^' to '#', picking the source round-robin.
- Drives the checker's freq input from the granted source's configuration.
- Captures the checker's verdict and returns it tagged with the source id; a broken line is aborted and the checker re-synced.

Parameters:
- N_SRC, 4, number of trace sources (2..8).
- SRC_W, 2, source id width, equal to clog2(N_SRC).
- MAX_LEN, 64, maximum characters per line including '^' and '#'.
- IDLE_CHAR, 8'h00, character driven to the checker when no line is active.
- ABORT_CHAR, 8'h0A, character injected to force the checker back to its idle state.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- src_valid  in  N_SRC  source i has a character available.
- src_char  in  8*N_SRC  character of source i, at bits [8i+7:8i].
- src_freq  in  16*N_SRC  freq value of source i.
- src_ready  out  N_SRC  character of source i is consumed this cycle.
- chk_char  out  8  character to the checker's char input.
- chk_freq  out  16  value to the checker's freq input.
- chk_format_type  in  2  format_type from the checker.
- chk_error_code  in  4  error_code from the checker.
- res_valid  out  1  one-cycle result pulse.
- res_src  out  SRC_W  id of the source the result belongs to.
- res_format  out  2  sampled format_type; 0 means the checker rejected the line.
- res_error  out  4  sampled error_code.
- res_abort  out  1  the line was aborted by this block.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, owner=0, len=0, chk_freq register=0; outputs res_valid=0, res_src=0, res_format=0, res_error=0, res_abort=0.
- The checker consumes one character every cycle. A bubble inside a line therefore corrupts the line, so this block never inserts a bubble silently.
- Request: a source requests when src_valid[i]=1 and its char is '^'.
- IDLE:
  - Winner = first requester scanning from rr_ptr upward, modulo N_SRC.
  - If a winner exists: src_ready[winner]=1, chk_char='^', chk_freq=src_freq[winner] combinationally (the checker samples freq on the '^' cycle). Latch owner=winner and its freq; rr_ptr<=winner+1 mod N_SRC; len<=1; go to LINE.
  - Sources with src_valid=1 and a non-'^' head char get src_ready=1 and the char is discarded (drain). Drain happens in IDLE only.
  - With no winner, chk_char=IDLE_CHAR.
- LINE:
  - chk_freq = latched value.
  - If src_valid[owner]=1: src_ready[owner]=1, chk_char=src_char[owner], len<=len+1.
  - If that char is '#', go to RESULT.
  - Else, if len+1 reaches MAX_LEN, go to ABORT.
  - If src_valid[owner]=0 (bubble): chk_char=ABORT_CHAR, go to ABORT_RES. The owner's later characters up to and including the next '#' are drained in ABORT_RES.
  - Intermediate '^' characters are forwarded unchanged; only '#' ends a line.
- RESULT (one cycle):
  - chk_char=IDLE_CHAR.
  - Sample chk_format_type and chk_error_code into res_*; res_src=owner, res_abort=0.
  - res_valid pulses on the next cycle. Go to IDLE.
- ABORT (one cycle): chk_char=ABORT_CHAR, then go to ABORT_RES.
- ABORT_RES:
  - chk_char=IDLE_CHAR.
  - Keep src_ready[owner]=1 while its char is not '#'. On '#', or on a cycle with src_valid[owner]=0, report the abort and go to IDLE.
  - Abort report: res_valid pulse with res_abort=1, res_format=0, res_error=0, res_src=owner.
- Latency: '#' consumed in cycle t → checker shows the verdict in t+1 (RESULT samples it) → res_valid=1 in t+2.
- Back-to-back lines from the same or another source are possible from cycle t+2 (IDLE).
- Width and counters: rr_ptr and owner are SRC_W bits; len is clog2(MAX_LEN)+1 bits and saturates at MAX_LEN.
- Reset asserted mid-line clears everything immediately. The checker is reset by the same top-level logic.

Decomposition:
- Shared package holds:
  - state encodings IDLE/LINE/RESULT/ABORT/ABORT_RES;
  - character constants: '^' 8'h5E, '#' 8'h23, IDLE_CHAR, ABORT_CHAR.
- One natural sub-module: rr_pick, a combinational round-robin priority picker over N_SRC request bits and rr_ptr that returns winner id and found.

Test Plan:
- Single source 0 sends "^10@00003000: $1 <= 0000000a#" with freq=4 → chk_char mirrors the stream; res_valid 2 cycles after '#' with res_src=0, res_format=01, res_error=0000.
- Sources 1 and 2 both present '^' in the same IDLE cycle, rr_ptr=0 → source 1 granted; source 2 is granted at the first IDLE after source 1's result; rr_ptr ends at 3.
- Source 3 line with pc 00002ffc and freq=8 → chk_freq=16'd8 during the whole line; res_format=01 with res_error bit 1 set.
- Owner deasserts src_valid after 5 characters → chk_char=8'h0A next cycle; remaining characters through '#' are drained; res_valid with res_abort=1 and res_src=owner.
- Line longer than MAX_LEN=64 → ABORT_CHAR injected on the 65th cycle; abort result reported; the next source is granted afterwards.
- Source 0 presents "xy^..." in IDLE → 'x' and 'y' are drained with src_ready=1, then '^' is granted; reset pulled low mid-line → all res_* outputs go to 0 at once and state returns to IDLE.
